// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse_sched round-robin impulse scheduler.
package pulse_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // A programmed period of 0 behaves as period 1 (an impulse every cycle).
    function automatic logic [31:0] eff_period(input logic [31:0] p);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/pulse_rr_arb.sv
// Combinational round-robin picker: first requester after last_grant_i wins.
module pulse_rr_arb
    import pulse_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  last_grant_i,
    output logic [NCH-1:0] grant_o,
    output logic [IW-1:0]  grant_idx_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        sum         = '0;
        idx         = '0;
        // k = NCH wraps back to last_grant itself, so it has lowest priority.
        for (int k = 1; k <= NCH; k++) begin
            sum = {1'b0, last_grant_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(NCH)) begin
                sum = sum - (IW+1)'(NCH);
            end
            idx = sum[IW-1:0];
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/pulse_sched.sv
// Shared periodic impulse engine: grants one requester at a time and plays
// its (period, count) burst as single-cycle impulses tagged with the channel.
module pulse_sched
    import pulse_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int PW  = 8,
    parameter int CW  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          req_valid,
    input  logic [NCH*PW-1:0]       req_period,
    input  logic [NCH*CW-1:0]       req_count,
    output logic [NCH-1:0]          req_ready,
    input  logic                    abort,
    output logic                    impulse,
    output logic [$clog2(NCH)-1:0]  impulse_ch,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted
);

    localparam int IW = $clog2(NCH);

    // Handshake: a burst is accepted in a cycle where req_valid[g] & req_ready[g].
    // req_ready is one-hot or zero, only in IDLE, and requesters hold their
    // payload stable until accepted.

    state_e         state_q, state_d;
    logic [PW-1:0]  period_q, period_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [CW-1:0]  remaining_q, remaining_d;
    logic [IW-1:0]  last_grant_q, last_grant_d;
    logic [IW-1:0]  ch_q, ch_d;
    logic           impulse_q, impulse_d;
    logic           done_q, done_d;
    logic           aborted_q, aborted_d;

    logic [NCH-1:0] grant;
    logic [IW-1:0]  grant_idx;
    logic           handshake;
    logic [PW-1:0]  sel_period;
    logic [CW-1:0]  sel_count;

    logic           step_en;
    logic [PW-1:0]  step_period;
    logic [PW-1:0]  step_phase;
    logic [CW-1:0]  step_rem;

    pulse_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    assign req_ready  = (state_q == IDLE) ? grant : '0;
    assign handshake  = |(req_valid & req_ready);
    assign sel_period = req_period[grant_idx*PW +: PW];
    assign sel_count  = req_count[grant_idx*CW +: CW];

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        phase_d      = phase_q;
        remaining_d  = remaining_q;
        last_grant_d = last_grant_q;
        ch_d         = ch_q;
        impulse_d    = 1'b0;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        step_en      = 1'b0;
        step_period  = period_q;
        step_phase   = phase_q;
        step_rem     = remaining_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d      = RUN;
                    last_grant_d = grant_idx;
                    ch_d         = grant_idx;
                    period_d     = PW'(eff_period(32'(sel_period)));
                    // The handshake cycle counts as phase 0, so impulses land at t+k*P.
                    step_period  = PW'(eff_period(32'(sel_period)));
                    step_phase   = '0;
                    step_rem     = sel_count;
                    if (sel_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        step_en = 1'b1;
                    end
                end
            end
            RUN: begin
                if (done_q) begin
                    state_d = IDLE;
                end else if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    step_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (step_en) begin
            if (step_phase == step_period - PW'(1)) begin
                impulse_d   = 1'b1;
                phase_d     = '0;
                remaining_d = step_rem - CW'(1);
                done_d      = (step_rem == CW'(1));
            end else begin
                phase_d     = step_phase + PW'(1);
                remaining_d = step_rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            period_q     <= '0;
            phase_q      <= '0;
            remaining_q  <= '0;
            last_grant_q <= IW'(NCH-1);
            ch_q         <= '0;
            impulse_q    <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            phase_q      <= phase_d;
            remaining_q  <= remaining_d;
            last_grant_q <= last_grant_d;
            ch_q         <= ch_d;
            impulse_q    <= impulse_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign impulse    = impulse_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign impulse_ch = ch_q;

endmodule

// File: doc/pulse_sched.md
# pulse_sched

Round-robin scheduler for a programmable periodic impulse generator. Up to `NCH` requesters each submit a burst descriptor (period, pulse count) over a valid/ready handshake. The block grants one requester at a time and emits that burst as single-cycle impulses tagged with the owning channel. It reports completion or abort, then returns to arbitration. It sits between control agents and any logic consuming timed strobes, so a single timing engine is shared instead of one fixed-period counter per consumer.

## Interface
- `NCH`, 4, number of requester channels (2..16)
- `PW`, 8, period field width
- `CW`, 8, pulse count field width
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `req_valid`  in  NCH  per-channel burst request
- `req_period`  in  NCH*PW  channel i period in bits [i*PW +: PW]
- `req_count`  in  NCH*CW  channel i pulse count in bits [i*CW +: CW]
- `req_ready`  out  NCH  one-hot (or zero) grant/accept
- `abort`  in  1  terminate the active burst
- `impulse`  out  1  one-cycle strobe
- `impulse_ch`  out  $clog2(NCH)  channel owning the current burst
- `busy`  out  1  burst active (state RUN)
- `done`  out  1  one-cycle pulse: burst completed normally
- `aborted`  out  1  one-cycle pulse: burst ended by abort

## Operation
- FSM states: IDLE and RUN.
- **IDLE**
  - Round-robin search over `req_valid`, starting at `last_grant+1` mod NCH.
  - `req_ready[g]` is asserted combinationally for the winner only.
  - Handshake is `req_valid[g] & req_ready[g]`. On handshake: latch period and count, set `impulse_ch=g`, set `last_grant=g`, go to RUN.
  - `last_grant` changes only on a handshake.
- **RUN**
  - Phase counter (PW bits) counts 0..P-1, where P = period, or 1 if period is 0.
  - Counter reaching P-1 registers `impulse=1` for the next cycle, clears the counter, and decrements `remaining`.
  - The last impulse carries `done=1` in the same cycle. The FSM is in IDLE the following cycle.
- Count 0: no impulse; `done` asserted one cycle after the handshake; IDLE the cycle after that.
- `abort`
  - Sampled high at the end of a RUN cycle in which `done` is not asserted: burst terminates, no further impulses, `aborted=1` in the next cycle, and that cycle is already IDLE (may accept).
  - Ignored in IDLE and in the `done` cycle (completion stands).
- `req_ready` is zero in RUN. Requesters hold valid and payload stable until accepted.
- `impulse_ch` holds the last granted channel until the next handshake.
- Reset values: `impulse=0`, `done=0`, `aborted=0`, `busy=0`, `impulse_ch=0`, state IDLE, counters 0, `last_grant=NCH-1` (channel 0 has first priority).

## Timing
- Handshake in cycle t, P≥1, C≥1:
  - impulses in cycles t+P, t+2P, … t+C·P
  - `done` in cycle t+C·P
  - earliest next handshake in cycle t+C·P+1
- `busy` is high in cycles t+1 … t+C·P.
- Outputs `impulse`, `done`, `aborted`, `busy` and `impulse_ch` are registered. `req_ready` is combinational from state, `req_valid` and `last_grant`.
- Reset wins over all other inputs in the same cycle. Reset mid-burst leaves all outputs at reset values in the next cycle and drops the burst silently (no `done` or `aborted`).

## Structure
- Package `pulse_sched_pkg`: state enum (IDLE, RUN), and a function for the period-0-to-1 mapping.
- Sub-module `pulse_rr_arb`: parameterised by NCH. Inputs: `req`, `last_grant`. Outputs: one-hot `grant` and encoded index. Purely combinational.
- The top level contains the FSM, the phase counter, the remaining-count register and the output registers.

## Test plan
- **Basic burst:** after reset, ch0 P=5 C=3 accepted at cycle t. Expect impulses at t+5, t+10, t+15; `done` at t+15; `impulse_ch=0`; `busy` high t+1..t+15.
- **Period 0 / count 0:**
  - ch1 P=0 C=2 → impulses at t+1 and t+2, `done` at t+2.
  - ch1 C=0 → no impulse, `done` at t+1.
- **Round-robin fairness:** all four channels valid continuously with P=1 C=1. Expect grant order 0,1,2,3,0; handshakes every 2 cycles; `req_ready` never multi-hot.
- **Abort mid-burst:** ch2 P=4 C=4, abort high at end of cycle t+6. Expect an impulse only at t+4, `aborted` at t+7, no `done`; a waiting ch3 is accepted at t+7.
- **Abort on last pulse:** P=2 C=1, abort in cycle t+2. Expect `done` at t+2 and no `aborted`.
- **Reset mid-burst:** ch3 P=3 C=5, reset in cycle t+7. Expect all outputs 0 from t+8; the next grant goes to ch0 when both ch0 and ch3 are valid.
